// File: rtl/fetch_buffer_pkg.sv
// Shared constants and state encoding for the instruction fetch buffer.
package fetch_buffer_pkg;

  // Number of buffered fetch entries; the occupancy FSM only covers 2.
  localparam int FB_DEPTH = 2;

  // Word presented to decode when no valid entry is available (sll $0,$0,0).
  localparam logic [31:0] NOP = 32'h0000_0000;

  // One entry holds {PC+4, instruction}.
  localparam int ENTRY_W = 64;

  // Occupancy FSM; the encoding doubles as the Count output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Entry storage and read/write pointers for the fetch buffer.
// Occupancy is tracked by the parent FSM, so push/pop arrive pre-qualified.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  // Next storage/pointer values; a simultaneous push and pop in the
  // one-entry case writes behind the head and advances onto it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage and pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_buffer.sv
// Two-entry decoupling buffer between instruction fetch and decode.
// Holds the occupancy FSM, the PC+4 adder and the NOP output gating.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCIn,
  input  logic [31:0] InstrIn,
  input  logic        FetchValid,
  output logic        FetchReady,
  input  logic        Flush,
  input  logic        DecodeReady,
  output logic        ValidOut,
  output logic [31:0] InstrOut,
  output logic [31:0] PCPlus4Out,
  output logic [1:0]  Count
);

  fb_state_e          state_q, state_d;
  logic               push, pop;
  logic [31:0]        pc_plus4;
  logic [ENTRY_W-1:0] head;

  // FetchReady depends only on registered state so the PC write-enable
  // never sees a combinational path from decode or branch resolution.
  assign FetchReady = (state_q != ST_FULL);
  assign ValidOut   = (state_q != ST_EMPTY) && !Flush;
  assign push       = FetchValid && FetchReady && !Flush;
  assign pop        = ValidOut && DecodeReady;
  assign pc_plus4   = PCIn + 32'd4;

  // Occupancy next-state; flush empties the buffer regardless of push/pop.
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .reset_i (Reset),
    .clear_i (Flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({pc_plus4, InstrIn}),
    .rdata_o (head)
  );

  assign InstrOut   = ValidOut ? head[31:0]  : NOP;
  assign PCPlus4Out = ValidOut ? head[63:32] : NOP;
  assign Count      = state_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed vector table, a streaming
// sequence, and randomized traffic against a queue-based reference model.
module tb_fetch_buffer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] PCIn = '0;
  logic [31:0] InstrIn = '0;
  logic        FetchValid = 1'b0;
  logic        FetchReady;
  logic        Flush = 1'b0;
  logic        DecodeReady = 1'b0;
  logic        ValidOut;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic [1:0]  Count;

  int n_pass = 0;
  int n_tot  = 0;

  fetch_buffer #(.DEPTH(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PCIn        (PCIn),
    .InstrIn     (InstrIn),
    .FetchValid  (FetchValid),
    .FetchReady  (FetchReady),
    .Flush       (Flush),
    .DecodeReady (DecodeReady),
    .ValidOut    (ValidOut),
    .InstrOut    (InstrOut),
    .PCPlus4Out  (PCPlus4Out),
    .Count       (Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, fv, fl, dr;
    logic [31:0] pc, ins;
    logic        chk;
    logic        e_v;
    logic [31:0] e_ins, e_pc4;
    logic [1:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] ins;
  } ent_t;

  vec_t vt[$];
  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Inputs change half a cycle before the edge; outputs are sampled 1ns later.
  task automatic drive(input logic rst, input logic fv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic fl, input logic dr);
    @(negedge Clk);
    Reset = rst; FetchValid = fv; PCIn = pc; InstrIn = ins; Flush = fl; DecodeReady = dr;
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc4, input logic [1:0] cnt, input logic rdy);
    chk({tag, ".valid"}, {31'd0, ValidOut}, {31'd0, v});
    chk({tag, ".instr"}, InstrOut, ins);
    chk({tag, ".pc4"},   PCPlus4Out, pc4);
    chk({tag, ".count"}, {30'd0, Count}, {30'd0, cnt});
    chk({tag, ".ready"}, {31'd0, FetchReady}, {31'd0, rdy});
  endtask

  // Reference behaviour: a FIFO of at most two {PC+4, instr} entries.
  task automatic model_edge();
    logic rdy, vld;
    rdy = (mq.size() < 2);
    vld = (mq.size() > 0) && !Flush;
    if (Reset || Flush) begin
      mq.delete();
    end else begin
      if (vld && DecodeReady) void'(mq.pop_front());
      if (FetchValid && rdy) mq.push_back('{pc4: PCIn + 32'd4, ins: InstrIn});
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fv, input logic [31:0] pc,
                              input logic [31:0] ins, input logic fl, input logic dr,
                              input logic c, input logic v, input logic [31:0] eins,
                              input logic [31:0] epc4, input logic [1:0] cnt, input logic rdy);
    vec_t r;
    r.rst = rst; r.fv = fv; r.pc = pc; r.ins = ins; r.fl = fl; r.dr = dr;
    r.chk = c; r.e_v = v; r.e_ins = eins; r.e_pc4 = epc4; r.e_cnt = cnt; r.e_rdy = rdy;
    return r;
  endfunction

  logic [31:0] sins [8];

  initial begin
    // rst fv pc ins fl dr | chk valid instr pc4 count ready
    vt.push_back(mk(1,0,32'h0,32'h0,0,0, 0,0,32'h0,32'h0,0,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,0, 1,0,32'h0,32'h0,0,1));
    // fill then drain
    vt.push_back(mk(0,1,32'h0,32'h8C010004,0,0, 1,0,32'h0,32'h0,0,1));
    vt.push_back(mk(0,1,32'h4,32'h00221820,0,0, 1,1,32'h8C010004,32'h4,1,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,0,        1,1,32'h8C010004,32'h4,2,0));
    vt.push_back(mk(0,0,32'h0,32'h0,0,1,        1,1,32'h8C010004,32'h4,2,0));
    vt.push_back(mk(0,0,32'h0,32'h0,0,1,        1,1,32'h00221820,32'h8,1,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,0,        1,0,32'h0,32'h0,0,1));
    // flush while full with fetch presented
    vt.push_back(mk(0,1,32'h100,32'h11111111,0,0, 1,0,32'h0,32'h0,0,1));
    vt.push_back(mk(0,1,32'h104,32'h22222222,0,0, 1,1,32'h11111111,32'h104,1,1));
    vt.push_back(mk(0,1,32'h108,32'h33333333,1,1, 1,0,32'h0,32'h0,2,0));
    vt.push_back(mk(0,0,32'h0,32'h0,0,1,          1,0,32'h0,32'h0,0,1));
    // flush drops a same-cycle push from empty
    vt.push_back(mk(0,1,32'h200,32'h44444444,1,0, 1,0,32'h0,32'h0,0,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,1,          1,0,32'h0,32'h0,0,1));
    // PC+4 wrap-around
    vt.push_back(mk(0,1,32'hFFFFFFFC,32'h55555555,0,0, 1,0,32'h0,32'h0,0,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,1,               1,1,32'h55555555,32'h0,1,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,0,               1,0,32'h0,32'h0,0,1));
    // reset dominates flush/push/pop in state ONE
    vt.push_back(mk(0,1,32'h10,32'h66666666,0,0, 1,0,32'h0,32'h0,0,1));
    vt.push_back(mk(1,1,32'h20,32'h77777777,1,1, 1,0,32'h0,32'h0,1,1));
    vt.push_back(mk(0,1,32'h40,32'h88888888,0,0, 1,0,32'h0,32'h0,0,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,0,         1,1,32'h88888888,32'h44,1,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,1,         1,1,32'h88888888,32'h44,1,1));
    vt.push_back(mk(0,0,32'h0,32'h0,0,0,         1,0,32'h0,32'h0,0,1));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].fv, vt[i].pc, vt[i].ins, vt[i].fl, vt[i].dr);
      if (vt[i].chk)
        check_all($sformatf("vec%0d", i), vt[i].e_v, vt[i].e_ins, vt[i].e_pc4,
                  vt[i].e_cnt, vt[i].e_rdy);
    end

    // Streaming: one entry in and one out every cycle after the first.
    drive(1, 0, 32'h0, 32'h0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      sins[k] = $urandom;
      drive(0, 1, 32'(4 * k), sins[k], 0, 1);
      if (k == 0)
        check_all("stream0", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      else
        check_all($sformatf("stream%0d", k), 1'b1, sins[k-1], 32'(4 * k), 2'd1, 1'b1);
    end
    drive(0, 0, 32'h0, 32'h0, 0, 1);
    check_all("stream_last", 1'b1, sins[7], 32'h20, 2'd1, 1'b1);
    drive(0, 0, 32'h0, 32'h0, 0, 0);
    check_all("stream_done", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Randomized traffic against the reference queue.
    drive(1, 0, 32'h0, 32'h0, 0, 0);
    mq.delete();
    @(posedge Clk);
    for (int c = 0; c < 400; c++) begin
      logic        r_rst, r_fv, r_fl, r_dr;
      logic [31:0] r_pc;
      logic        e_v;
      r_rst = ($urandom_range(0, 49) == 0);
      r_fl  = ($urandom_range(0, 9) == 0);
      r_fv  = ($urandom_range(0, 3) != 0);
      r_dr  = ($urandom_range(0, 2) != 0);
      r_pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFF_FFFC);
      drive(r_rst, r_fv, r_pc, $urandom, r_fl, r_dr);
      e_v = (mq.size() > 0) && !r_fl;
      check_all($sformatf("rnd%0d", c), e_v,
                e_v ? mq[0].ins : 32'h0, e_v ? mq[0].pc4 : 32'h0,
                2'(mq.size()), (mq.size() < 2));
      model_edge();
      @(posedge Clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DEPTH, 2, number of buffered fetch entries; only 2 is supported.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- Clk  in  1  sole clock; all state updates on posedge Clk.
- Reset  in  1  synchronous, active-high reset, sampled on posedge Clk.
- PCIn  in  32  current PC from the program counter register.
- InstrIn  in  32  instruction word read combinationally from instruction memory at PCIn.
- FetchValid  in  1  PCIn/InstrIn are a real fetch this cycle.
- FetchReady  out  1  buffer accepts the fetch; drives the PC write-enable.
- Flush  in  1  discard all buffered and same-cycle fetches (branch/jump taken).
- DecodeReady  in  1  decode stage consumes the head entry this cycle.
- ValidOut  out  1  head entry is valid for decode.
- InstrOut  out  32  head instruction word.
- PCPlus4Out  out  32  head entry's PC + 4.
- Count  out  2  number of occupied entries (0..2).

Function
REQ-003 The block SHALL be a 2-entry FIFO of {PCIn+4, InstrIn} with occupancy FSM states EMPTY (0), ONE (1) and FULL (2).
REQ-004 A push SHALL occur when FetchValid && FetchReady && !Flush; the entry SHALL be visible at the outputs no earlier than the next cycle.
REQ-005 A pop SHALL occur when ValidOut && DecodeReady.
REQ-006 FetchReady SHALL be (state != FULL); it SHALL NOT depend combinationally on DecodeReady or Flush.
REQ-007 ValidOut SHALL be (state != EMPTY) && !Flush.
REQ-008 State transitions SHALL be:
- EMPTY->ONE on push.
- ONE->FULL on push without pop.
- ONE->EMPTY on pop without push.
- FULL->ONE on pop.
- Push with pop in ONE SHALL stay ONE.
- All other cases SHALL hold state.
REQ-009 In state ONE, a simultaneous push and pop SHALL replace the head with the new entry, with no bubble and no loss.
REQ-010 PCPlus4Out SHALL be PCIn+4 computed modulo 2^32 at push time; 0xFFFFFFFC SHALL yield 0x00000000.
REQ-011 When ValidOut=0, InstrOut and PCPlus4Out SHALL read 32'h00000000 (NOP, sll $0,$0,0).
REQ-012 When Flush=1, all entries SHALL be cleared at the next edge (state EMPTY), the same-cycle push SHALL be dropped, and no pop SHALL occur.
REQ-013 Entries SHALL leave in push order; no entry SHALL be duplicated or reordered.
REQ-014 Count SHALL equal the FSM occupancy and update on the same edge as the state.

Reset
REQ-015 When Reset=1 at posedge Clk, the state SHALL become EMPTY, pointers 0, and stored entries 0.
REQ-016 After reset the outputs SHALL be ValidOut=0, InstrOut=0, PCPlus4Out=0, Count=0, FetchReady=1.
REQ-017 Reset SHALL dominate Flush, push and pop in the same cycle.
REQ-018 Reset asserted mid-operation SHALL discard all entries; the first post-reset push SHALL appear as the head.

Structure
REQ-019 A shared package SHALL hold DEPTH, the NOP constant 32'h00000000, the entry width 64, and the FSM state encoding (EMPTY/ONE/FULL).
REQ-020 Entry storage and pointers SHALL reside in one sub-module, fetch_fifo; fetch_buffer SHALL hold the FSM, the PC+4 adder and the output gating.

Verification
REQ-021 Reset then idle: Reset=1 for 1 cycle -> ValidOut=0, FetchReady=1, Count=0, InstrOut=0.
REQ-022 Fill and drain: push (PC 0x0, instr 0x8C010004) and (PC 0x4, 0x00221820) with DecodeReady=0 -> Count=2, FetchReady=0; then DecodeReady=1 -> outputs {0x4, 0x8C010004}, then {0x8, 0x00221820}, then ValidOut=0.
REQ-023 Streaming: FetchValid=1 and DecodeReady=1 every cycle for 8 sequential PCs from 0x0 -> one entry out per cycle in order, Count stays 1, no bubbles after the first.
REQ-024 Flush while FULL with a same-cycle push: Flush=1 -> next cycle Count=0, ValidOut=0, the pushed entry never appears, FetchReady=1.
REQ-025 Wrap-around: PCIn=0xFFFFFFFC -> PCPlus4Out=0x00000000.
REQ-026 Reset with Flush and push asserted while state ONE -> EMPTY; the next push at PC 0x40 appears with PCPlus4Out=0x44.
